// File: rtl/config_loader.sv
// config_loader: packs an IN_W-bit valid/ready config stream into WORD_W-bit
// words and writes them, one per enable pulse, into a bank of NUM_WORDS
// level-sensitive latches. Each enable pulse is framed by a setup cycle and
// a hold cycle so that the data bus is stable around every pulse.
// Optional feature macro: CONFIG_LOADER_CHECKSUM_EN. When defined, one
// trailing checksum word is accepted after the last latch word and compared
// with the XOR of all latch words; io_err reports a mismatch.
// WORD_W must be an integer multiple of IN_W, with at least two beats per word.
module config_loader #(
  parameter int unsigned NUM_WORDS = 9,
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned IN_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_start,
  input  logic                 io_in_valid,
  output logic                 io_in_ready,
  input  logic [IN_W-1:0]      io_in_data,
  output logic [WORD_W-1:0]    io_d_out,
  output logic [NUM_WORDS-1:0] io_configs_en,
  output logic                 io_busy,
  output logic                 io_done,
  output logic                 io_err
);

  localparam int unsigned BEATS  = WORD_W / IN_W;
  localparam int unsigned SH_W   = WORD_W - IN_W;
  localparam int unsigned BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned WIDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ASSEMBLE = 3'd1,
    SETUP    = 3'd2,
    STROBE   = 3'd3,
    HOLD     = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t              state;
  logic [BIDX_W-1:0]   beat_idx;
  logic [WIDX_W-1:0]   word_idx;
  logic [SH_W-1:0]     shift;
  logic [WORD_W-1:0]   word_c;
  logic                accept_c;
  logic                last_beat_c;

`ifdef CONFIG_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0]   xsum;
  logic                chk_phase;
`else
  assign io_err = 1'b0;
`endif

  // Earlier beats sit in the shift register; the incoming beat becomes the MSBs,
  // so after BEATS beats the first beat ends up in the LSBs.
  assign word_c      = {io_in_data, shift};
  assign accept_c    = io_in_valid && io_in_ready;
  assign last_beat_c = (beat_idx == BIDX_W'(BEATS - 1));

  // Load sequencer: state, counters, packing register and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      beat_idx      <= '0;
      word_idx      <= '0;
      shift         <= '0;
      io_in_ready   <= 1'b0;
      io_d_out      <= '0;
      io_configs_en <= '0;
      io_busy       <= 1'b0;
      io_done       <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
      io_err        <= 1'b0;
      xsum          <= '0;
      chk_phase     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (io_start) begin
            state       <= ASSEMBLE;
            beat_idx    <= '0;
            word_idx    <= '0;
            io_in_ready <= 1'b1;
            io_busy     <= 1'b1;
            io_done     <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            io_err      <= 1'b0;
            xsum        <= '0;
            chk_phase   <= 1'b0;
`endif
          end
        end

        ASSEMBLE: begin
          if (accept_c) begin
            shift <= word_c[WORD_W-1:IN_W];
            if (last_beat_c) begin
              beat_idx    <= '0;
              io_in_ready <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
              if (chk_phase) begin
                // Checksum word: no latch write, finish and report.
                state   <= DONE;
                io_busy <= 1'b0;
                io_done <= 1'b1;
                io_err  <= (word_c != xsum);
              end else begin
                state    <= SETUP;
                io_d_out <= word_c;
                xsum     <= xsum ^ word_c;
              end
`else
              state    <= SETUP;
              io_d_out <= word_c;
`endif
            end else begin
              beat_idx <= beat_idx + 1'b1;
            end
          end
        end

        SETUP: begin
          state         <= STROBE;
          io_configs_en <= NUM_WORDS'(1) << word_idx;
        end

        STROBE: begin
          state         <= HOLD;
          io_configs_en <= '0;
        end

        HOLD: begin
          if (word_idx == WIDX_W'(NUM_WORDS - 1)) begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
            state       <= ASSEMBLE;
            chk_phase   <= 1'b1;
            io_in_ready <= 1'b1;
`else
            state   <= DONE;
            io_busy <= 1'b0;
            io_done <= 1'b1;
`endif
          end else begin
            state       <= ASSEMBLE;
            word_idx    <= word_idx + 1'b1;
            io_in_ready <= 1'b1;
          end
        end

        default: begin
          state         <= IDLE;
          io_in_ready   <= 1'b0;
          io_configs_en <= '0;
          io_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: directed scoreboard bench for config_loader.
// The stimulus process pushes the expected (data, enable) pair of every latch
// write into a queue; a monitor pops and compares on every enable pulse and
// also checks data stability around each pulse.
module tb_config_loader;

  localparam int unsigned NW = 9;
  localparam int unsigned WW = 32;
  localparam int unsigned IW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          io_start;
  logic          io_in_valid;
  logic          io_in_ready;
  logic [IW-1:0] io_in_data;
  logic [WW-1:0] io_d_out;
  logic [NW-1:0] io_configs_en;
  logic          io_busy;
  logic          io_done;
  logic          io_err;

  typedef struct packed {
    logic [WW-1:0] d;
    logic [NW-1:0] en;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic [WW-1:0] prev_d  = '0;
  logic [NW-1:0] prev_en = '0;

  config_loader #(.NUM_WORDS(NW), .WORD_W(WW), .IN_W(IW)) dut (
    .clk           (clk),
    .reset         (reset),
    .io_start      (io_start),
    .io_in_valid   (io_in_valid),
    .io_in_ready   (io_in_ready),
    .io_in_data    (io_in_data),
    .io_d_out      (io_d_out),
    .io_configs_en (io_configs_en),
    .io_busy       (io_busy),
    .io_done       (io_done),
    .io_err        (io_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [WW-1:0] word_of(input int mode, input int k);
    logic [7:0] b0, b1, b2, b3;
    if (mode == 0) begin
      b0 = 8'(4 * k);
      b1 = 8'(4 * k + 1);
      b2 = 8'(4 * k + 2);
      b3 = 8'(4 * k + 3);
      return {b3, b2, b1, b0};
    end
    return 32'h1111_1111;
  endfunction

  // Monitor: scoreboard pop on every enable pulse, plus setup/hold stability.
  always @(negedge clk) begin
    if (reset) begin
      prev_en = '0;
      prev_d  = io_d_out;
    end else begin
      if (io_configs_en != '0) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", 64'(io_configs_en), 64'h0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("en_pulse", 64'(io_configs_en), 64'(e.en));
          chk("d_at_pulse", 64'(io_d_out), 64'(e.d));
        end
        chk("d_setup", 64'(io_d_out), 64'(prev_d));
      end else if (prev_en != '0) begin
        chk("d_hold", 64'(io_d_out), 64'(prev_d));
      end
      prev_en = io_configs_en;
      prev_d  = io_d_out;
    end
  end

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send_beat(input logic [IW-1:0] b, input logic st);
    int n;
    n = 0;
    io_in_valid = 1'b1;
    io_in_data  = b;
    io_start    = st;
    while (!io_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!io_in_ready) chk("ready_timeout", 64'(io_in_ready), 64'h1);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue io_start; called at a negedge, returns at the negedge after start was sampled.
  task automatic do_start(output int c0);
    io_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io_start = 1'b0;
    c0 = cyc;
    chk("start_busy", 64'(io_busy), 64'h1);
    chk("start_done_clr", 64'(io_done), 64'h0);
    chk("start_ready", 64'(io_in_ready), 64'h1);
  endtask

  task automatic push_words(input int mode);
    for (int k = 0; k < int'(NW); k++) begin
      exp_t e;
      e.d  = word_of(mode, k);
      e.en = NW'(1) << k;
      q.push_back(e);
    end
  endtask

  // mode 0: incrementing bytes; mode 1: 0x11 words, good checksum; mode 2: 0x11 words, bad checksum.
  task automatic do_load(input int mode, input int stall_at, input int start_at);
    int c0, n, exp_cyc;
    logic [WW-1:0] xs;
    logic [WW-1:0] ck;
    logic exp_err;
    xs = '0;
    exp_err = 1'b0;
    exp_cyc = 7 * int'(NW) + ((stall_at >= 0) ? 5 : 0);
    push_words(mode);
    for (int k = 0; k < int'(NW); k++) xs = xs ^ word_of(mode, k);
    do_start(c0);
    for (int i = 0; i < 4 * int'(NW); i++) begin
      send_beat((mode == 0) ? 8'(i) : 8'h11, (i == start_at) ? 1'b1 : 1'b0);
      io_start = 1'b0;
      if (i == stall_at) begin
        io_in_valid = 1'b0;
        for (int s = 0; s < 5; s++) begin
          chk("ready_in_stall", 64'(io_in_ready), 64'h1);
          @(negedge clk);
        end
      end
    end
`ifdef CONFIG_LOADER_CHECKSUM_EN
    ck = (mode == 2) ? '0 : xs;
    exp_err = (mode == 2);
    exp_cyc = exp_cyc + 4;
    for (int b = 0; b < 4; b++) send_beat(ck[8*b +: 8], 1'b0);
`else
    ck = xs;
`endif
    io_in_valid = 1'b0;
    n = 0;
    while (!io_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done", 64'(io_done), 64'h1);
    chk("load_cycles", 64'(cyc - c0), 64'(exp_cyc));
    chk("busy_low", 64'(io_busy), 64'h0);
    chk("ready_low", 64'(io_in_ready), 64'h0);
    chk("err", 64'(io_err), 64'(exp_err));
    chk("d_final", 64'(io_d_out), 64'(word_of(mode, int'(NW) - 1)));
    chk("queue_drained", 64'(q.size()), 64'h0);
    repeat (3) @(negedge clk);
    chk("done_held", 64'(io_done), 64'h1);
  endtask

  initial begin
    int c0, n;
    reset       = 1'b0;
    io_start    = 1'b0;
    io_in_valid = 1'b0;
    io_in_data  = '0;
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(io_in_ready), 64'h0);
    chk("rst_d", 64'(io_d_out), 64'h0);
    chk("rst_en", 64'(io_configs_en), 64'h0);
    chk("rst_busy", 64'(io_busy), 64'h0);
    chk("rst_done", 64'(io_done), 64'h0);
    chk("rst_err", 64'(io_err), 64'h0);
    reset = 1'b0;
    @(negedge clk);

    // Back-to-back beats, then a load with a stall and an ignored mid-load start.
    do_load(0, -1, -1);
    do_load(0, 18, 6);

    // Reset during the strobe of word 3.
    push_words(0);
    do_start(c0);
    for (int i = 0; i < 16; i++) send_beat(8'(i), 1'b0);
    io_in_valid = 1'b0;
    n = 0;
    while (io_configs_en != NW'(9'h008) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("w3_strobe", 64'(io_configs_en), 64'h8);
    #1 reset = 1'b1;
    #1;
    chk("arst_en", 64'(io_configs_en), 64'h0);
    chk("arst_d", 64'(io_d_out), 64'h0);
    chk("arst_busy", 64'(io_busy), 64'h0);
    chk("arst_ready", 64'(io_in_ready), 64'h0);
    chk("arst_done", 64'(io_done), 64'h0);
    q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_load(0, -1, -1);

`ifdef CONFIG_LOADER_CHECKSUM_EN
    do_load(1, -1, -1);
    do_load(2, -1, -1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
